// File: rtl/exe_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring, 34-cycle stall then a one-cycle done; zero/overflow short path done next cycle.
// Holds the pipeline through stall_o while busy; flush aborts at once and leaves result_o untouched.
module exe_div_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        reg_we_o,
  output logic [31:0] result_o
);

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t                  state;
  logic                    is_rem_q;
  logic                    neg_quo_q;
  logic                    neg_rem_q;
  logic [DATA_WIDTH-1:0]   dvd_q;
  logic [DATA_WIDTH-1:0]   dvs_q;
  logic [DATA_WIDTH:0]     rem_q;
  logic [4:0]              cnt_q;

  logic                    start;
  logic                    op_signed;
  logic                    op1_neg;
  logic                    op2_neg;
  logic [DATA_WIDTH-1:0]   op1_mag;
  logic [DATA_WIDTH-1:0]   op2_mag;
  logic                    div_zero;
  logic                    overflow;
  logic [DATA_WIDTH:0]     rem_shift;
  logic [DATA_WIDTH:0]     rem_sub;
  logic                    q_bit;
  logic [DATA_WIDTH-1:0]   quo_fix;
  logic [DATA_WIDTH-1:0]   rem_fix;

  // rst_i gating keeps stall_o low while reset is held, even with a request pending
  assign start     = rst_i & valid_i & funct3_i[2] & (state == IDLE) & ~flush_i;
  assign op_signed = ~funct3_i[0];
  assign op1_neg   = op_signed & op1_i[DATA_WIDTH-1];
  assign op2_neg   = op_signed & op2_i[DATA_WIDTH-1];
  assign op1_mag   = op1_neg ? (DATA_WIDTH'(0) - op1_i) : op1_i;
  assign op2_mag   = op2_neg ? (DATA_WIDTH'(0) - op2_i) : op2_i;
  assign div_zero  = (op2_i == '0);
  assign overflow  = op_signed & (op1_i == 32'h8000_0000) & (op2_i == 32'hFFFF_FFFF);

  // The dividend register doubles as the quotient: bits shift out the top, quotient bits enter the bottom
  assign rem_shift = {rem_q[DATA_WIDTH-1:0], dvd_q[DATA_WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift - {1'b0, dvs_q};

  assign quo_fix   = neg_quo_q ? (DATA_WIDTH'(0) - dvd_q) : dvd_q;
  assign rem_fix   = neg_rem_q ? (DATA_WIDTH'(0) - rem_q[DATA_WIDTH-1:0]) : rem_q[DATA_WIDTH-1:0];

  assign stall_o   = start | (~flush_i & ((state == BUSY) | (state == FIX)));
  assign done_o    = (state == DONE) & ~flush_i;
  assign reg_we_o  = done_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_rem_q  <= funct3_i[1];
            neg_quo_q <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            dvd_q     <= op1_mag;
            dvs_q     <= op2_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            if (div_zero) begin
              result_o <= funct3_i[1] ? op1_i : 32'hFFFF_FFFF;
              state    <= DONE;
            end else if (overflow) begin
              result_o <= funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= q_bit ? rem_sub : rem_shift;
          dvd_q <= {dvd_q[DATA_WIDTH-2:0], q_bit};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_o <= is_rem_q ? rem_fix : quo_fix;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exe_div_seq.md
# exe_div_seq

Multi-cycle sequencer for RV32M divide and remainder (DIV, DIVU, REM, REMU) in the execute stage. It accepts a decoded divide request from exe, holds the pipeline via a stall to the hdu, and runs a radix-2 restoring division over 32 iterations. It returns a registered result and a one-cycle write-enable for the exe result mux. Divide-by-zero and signed overflow take a short path.

## Interface

- No parameters; width fixed at `DATA_WIDTH` (32).
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  exe holds an R_M-opcode instruction with funct7 = 0000001; level, held while stall_o is high.
- funct3_i  in  3  100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU. Values below 100 are ignored (multiply is handled elsewhere).
- op1_i  in  32  dividend.
- op2_i  in  32  divisor.
- flush_i  in  1  pipeline flush; aborts any operation in progress.
- stall_o  out  1  to hdu; holds pc, if_id, id_exe and exe.
- done_o  out  1  one-cycle pulse; result_o is valid.
- reg_we_o  out  1  equals done_o.
- result_o  out  32  quotient or remainder, registered.

## Operation

- States: IDLE, BUSY, FIX, DONE.
- start = valid_i & funct3_i[2] & state==IDLE & !flush_i.
- IDLE, start: latch op/signed flags, |op1|, |op2|, sign of op1, and sign of op1 XOR sign of op2.
  - Signed ops use two's-complement magnitudes; unsigned ops pass operands as-is.
  - Clear the 33-bit partial remainder and the 5-bit counter.
  - Next state: DONE if op2 == 0 or (signed & op1 == 0x80000000 & op2 == 0xFFFFFFFF); otherwise BUSY.
  - Short-path result is loaded directly:
    - div-by-zero: quotient 0xFFFFFFFF, remainder op1.
    - overflow: quotient 0x80000000, remainder 0.
- BUSY, per cycle:
  - rem = {rem[31:0], dividend[31]}; shift dividend left.
  - If rem >= divisor: rem -= divisor and set quotient LSB to 1; else set it to 0.
  - counter += 1. After the iteration with counter == 31, go to FIX.
- FIX: sign correction.
  - Quotient is negated if signed and the sign-XOR flag is set.
  - Remainder is negated if signed and the dividend sign is set.
  - Select quotient (funct3[1] = 0) or remainder (funct3[1] = 1) into result_o. Go to DONE.
- DONE: done_o = reg_we_o = 1 for this cycle only. Next state is IDLE unconditionally.
- stall_o (combinational) = start | state==BUSY | state==FIX. It is low in DONE so the pipeline advances with the result.
- flush_i high in any state: next state IDLE, done_o suppressed, stall_o low in the same cycle, result_o keeps its previous value.
- valid_i low while BUSY/FIX is ignored; the operation completes using latched operands.

## Timing

- Reset (rst_i low, async): state IDLE, stall_o 0, done_o 0, reg_we_o 0, result_o 0x00000000, counter 0.
- Normal op with request in cycle 0:
  - stall_o high in cycles 0–33: 1 start cycle + 32 BUSY cycles + 1 FIX cycle.
  - done_o and result_o valid in cycle 34.
- Short path: stall_o high in cycle 0 only; done_o in cycle 1.
- Back-to-back divides: DONE in cycle N, IDLE in N+1; a new start in N+1 is accepted (stall_o high in N+1).
- Simultaneous flush_i and start: flush wins, no operation starts.
- Reset mid-operation: immediate return to IDLE, no done pulse after release.
- Counter is 5 bits and wraps to 0 on the BUSY→FIX transition.

## Test plan

- DIVU op1 = 100, op2 = 7: stall_o high cycles 0–33; cycle 34 done_o = 1, result_o = 14. REMU with the same operands returns 2.
- DIV op1 = 0xFFFFFFF9 (−7), op2 = 2: result_o 0xFFFFFFFD (−3). REM with the same operands returns 0xFFFFFFFF (−1).
- DIVU 0x1234 / 0: done_o in cycle 1, result_o 0xFFFFFFFF. REM 0x1234 / 0 returns 0x1234.
- DIV 0x80000000 / 0xFFFFFFFF: done in cycle 1, result_o 0x80000000. REM with the same operands returns 0.
- DIV started, flush_i at cycle 10: stall_o 0 in cycle 10, state IDLE, no done_o through cycle 40. A follow-up DIVU 9/3 returns 3 at 34 cycles after its start.
- rst_i low at cycle 20 of an operation: all outputs 0 immediately. After release, the same request restarts and completes with the correct result 34 cycles after its start.
